// File: rtl/fifo_axis_pkg.sv
// Shared types for the FIFO-to-AXI4-Stream drain stage: FSM state encoding
// and the {data,last} beat layout held in the output buffer.
package fifo_axis_pkg;

  localparam int AXIS_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } drain_state_t;

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] data;
    logic                       last;
  } axis_beat_t;

endpackage

// File: rtl/fifo_axis_drain_skid_buf.sv
// Two-entry {data,last} output buffer. Entry 0 is always the head; a push and
// pop in the same cycle at occupancy 1 replaces the head so throughput is 1/clk.
module axis_skid_buf
  import fifo_axis_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] pushData_i,
  input  logic                  pushLast_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] headData_o,
  output logic                  headLast_o,
  output logic [1:0]            occ_o
);

  logic [DATA_WIDTH:0] entry0_q, entry0_d;
  logic [DATA_WIDTH:0] entry1_q, entry1_d;
  logic [1:0]          occ_q, occ_d;
  logic                doPop, doPush;
  logic [DATA_WIDTH:0] pushBeat;

  assign pushBeat = {pushData_i, pushLast_i};
  assign doPop    = pop_i && (occ_q != 2'd0);
  assign doPush   = push_i && ((occ_q != 2'd2) || doPop);

  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    occ_d    = occ_q;
    case (occ_q)
      2'd0: begin
        if (doPush) begin
          entry0_d = pushBeat;
          occ_d    = 2'd1;
        end
      end
      2'd1: begin
        if (doPush && doPop) begin
          entry0_d = pushBeat;
        end else if (doPush) begin
          entry1_d = pushBeat;
          occ_d    = 2'd2;
        end else if (doPop) begin
          occ_d = 2'd0;
        end
      end
      default: begin
        // Full: a pop promotes the second entry to the head.
        if (doPop) begin
          entry0_d = entry1_q;
          if (doPush) begin
            entry1_d = pushBeat;
          end else begin
            occ_d = 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry0_q <= '0;
      entry1_q <= '0;
      occ_q    <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      occ_q    <= occ_d;
    end
  end

  assign headData_o = entry0_q[DATA_WIDTH:1];
  assign headLast_o = entry0_q[0];
  assign occ_o      = occ_q;

endmodule

// File: rtl/fifo_axis_drain.sv
// Pops a show-ahead FIFO and streams the words as AXI4-Stream packets with TLAST.
// Optional beat-with-TLAST counter port PKT_COUNT when FIFO_AXIS_STATS_EN is defined.
module fifo_axis_drain
  import fifo_axis_pkg::*;
#(
  parameter  int DATA_WIDTH  = 32,
  parameter  int MAX_PKT_LEN = 256,
  localparam int CNT_W       = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  ENABLE,
  input  logic [CNT_W-1:0]      CFG_PKT_LEN,
  output logic                  BUSY,
  output logic                  RD_CMD,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  input  logic                  FIFO_EMPTY,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY
`ifdef FIFO_AXIS_STATS_EN
  ,
  output logic [31:0]           PKT_COUNT
`endif
);

  drain_state_t     state_q, state_d;
  logic [CNT_W-1:0] rdBeat_q, rdBeat_d;
  logic [CNT_W-1:0] pktLen_q, pktLen_d;
  logic [1:0]       occ;
  logic             stopPending;
  logic             isLast;
  logic             rdCmd;
  logic             handshake;

  // Stopping is only allowed on a packet boundary, i.e. before the first pop.
  assign stopPending = !ENABLE && (rdBeat_q == '0);
  assign isLast      = (rdBeat_q == pktLen_q - CNT_W'(1));
  assign handshake   = M_AXIS_TVALID && M_AXIS_TREADY;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= IDLE;
      rdBeat_q <= '0;
      pktLen_q <= '0;
    end else begin
      state_q  <= state_d;
      rdBeat_q <= rdBeat_d;
      pktLen_q <= pktLen_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rdBeat_d = rdBeat_q;
    pktLen_d = pktLen_q;
    case (state_q)
      IDLE: begin
        if (ENABLE) begin
          pktLen_d = (CFG_PKT_LEN == '0) ? CNT_W'(MAX_PKT_LEN) : CFG_PKT_LEN;
          rdBeat_d = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (rdCmd) begin
          rdBeat_d = isLast ? '0 : rdBeat_q + CNT_W'(1);
        end
        if (stopPending) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (occ == 2'd0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The pop strobe never looks at TREADY; the buffer absorbs the stall.
  always_comb begin
    BUSY  = (state_q != IDLE);
    rdCmd = (state_q == STREAM) && !FIFO_EMPTY && (occ < 2'd2) && !stopPending;
  end

  assign RD_CMD        = rdCmd;
  assign M_AXIS_TVALID = (occ != 2'd0);

  axis_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid_buf (
    .clk_i      (CLK),
    .rst_ni     (RESETN),
    .push_i     (rdCmd),
    .pushData_i (RD_DATA),
    .pushLast_i (isLast),
    .pop_i      (M_AXIS_TREADY),
    .headData_o (M_AXIS_TDATA),
    .headLast_o (M_AXIS_TLAST),
    .occ_o      (occ)
  );

`ifdef FIFO_AXIS_STATS_EN
  logic [31:0] pktCount_q, pktCount_d;

  assign pktCount_d = (handshake && M_AXIS_TLAST) ? pktCount_q + 32'd1 : pktCount_q;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pktCount_q <= '0;
    end else begin
      pktCount_q <= pktCount_d;
    end
  end

  assign PKT_COUNT = pktCount_q;
`else
  logic unusedHandshake;
  assign unusedHandshake = handshake;
`endif

endmodule

// File: tb/tb_fifo_axis_drain.sv
// Directed bench for fifo_axis_drain: a model FIFO feeds the read port and a
// negedge monitor records accepted beats and tracks expected buffer occupancy.
module tb_fifo_axis_drain;

  localparam int DW   = 32;
  localparam int MAXL = 256;
  localparam int CW   = 9;

  logic          CLK = 1'b0;
  logic          RESETN;
  logic          ENABLE;
  logic [CW-1:0] CFG_PKT_LEN;
  logic          BUSY;
  logic          RD_CMD;
  logic [DW-1:0] RD_DATA;
  logic          FIFO_EMPTY;
  logic [DW-1:0] M_AXIS_TDATA;
  logic          M_AXIS_TVALID;
  logic          M_AXIS_TLAST;
  logic          M_AXIS_TREADY;
`ifdef FIFO_AXIS_STATS_EN
  logic [31:0]   PKT_COUNT;
`endif

  int tests = 0;
  int fails = 0;

  fifo_axis_drain #(.DATA_WIDTH(DW), .MAX_PKT_LEN(MAXL)) dut (
    .CLK           (CLK),
    .RESETN        (RESETN),
    .ENABLE        (ENABLE),
    .CFG_PKT_LEN   (CFG_PKT_LEN),
    .BUSY          (BUSY),
    .RD_CMD        (RD_CMD),
    .RD_DATA       (RD_DATA),
    .FIFO_EMPTY    (FIFO_EMPTY),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TREADY (M_AXIS_TREADY)
`ifdef FIFO_AXIS_STATS_EN
    ,
    .PKT_COUNT     (PKT_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Show-ahead FIFO model; the bench only ever writes wrPtr.
  logic [31:0] fifoMem [0:2047];
  logic [10:0] rdPtr = 11'd0;
  logic [10:0] wrPtr = 11'd0;

  assign RD_DATA    = fifoMem[rdPtr];
  assign FIFO_EMPTY = (rdPtr == wrPtr);

  always @(posedge CLK) begin
    if (RD_CMD && !FIFO_EMPTY) rdPtr <= rdPtr + 11'd1;
  end

  int cycle = 0;
  always @(posedge CLK) cycle <= cycle + 1;

  logic [31:0] capData [0:1023];
  logic        capLast [0:1023];
  int          capCyc  [0:1023];
  int          capCnt   = 0;
  int          tbOcc    = 0;
  int          validErr = 0;
  int          stallErr = 0;
  int          occ2Err  = 0;
  logic        prevStall = 1'b0;
  logic [31:0] prevData  = '0;
  logic        prevLast  = 1'b0;

  // Monitor samples mid-cycle; inputs change only 1 time unit after posedge.
  always @(negedge CLK) begin
    if (!RESETN) begin
      tbOcc     = 0;
      prevStall = 1'b0;
    end else begin
      if (RD_CMD && tbOcc == 2) occ2Err++;
      if (M_AXIS_TVALID !== (tbOcc != 0)) validErr++;
      if (prevStall && (M_AXIS_TDATA !== prevData || M_AXIS_TLAST !== prevLast)) stallErr++;
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        capData[capCnt] = M_AXIS_TDATA;
        capLast[capCnt] = M_AXIS_TLAST;
        capCyc[capCnt]  = cycle;
        capCnt++;
      end
      tbOcc = tbOcc + ((RD_CMD && !FIFO_EMPTY) ? 1 : 0) - ((M_AXIS_TVALID && M_AXIS_TREADY) ? 1 : 0);
      prevStall = M_AXIS_TVALID && !M_AXIS_TREADY;
      prevData  = M_AXIS_TDATA;
      prevLast  = M_AXIS_TLAST;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic loadFifo(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fifoMem[wrPtr] = base + 32'(i);
      wrPtr = wrPtr + 11'd1;
    end
  endtask

  task automatic applyReset();
    RESETN        = 1'b0;
    ENABLE        = 1'b0;
    M_AXIS_TREADY = 1'b1;
    tick(2);
    wrPtr  = rdPtr;
    RESETN = 1'b1;
    tick(1);
  endtask

  task automatic waitBeats(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (capCnt >= target) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    if (capCnt >= target) ok = 1'b1;
  endtask

  task automatic test_reset();
    RESETN        = 1'b0;
    ENABLE        = 1'b0;
    CFG_PKT_LEN   = 9'd4;
    M_AXIS_TREADY = 1'b1;
    tick(2);
    tests++; if (BUSY !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %0b expected 0", BUSY); end
    tests++; if (RD_CMD !== 1'b0) begin fails++; $display("[TB] FAIL reset_rdcmd: got %0b expected 0", RD_CMD); end
    tests++; if (M_AXIS_TVALID !== 1'b0) begin fails++; $display("[TB] FAIL reset_tvalid: got %0b expected 0", M_AXIS_TVALID); end
    tests++; if (M_AXIS_TLAST !== 1'b0) begin fails++; $display("[TB] FAIL reset_tlast: got %0b expected 0", M_AXIS_TLAST); end
    tests++; if (M_AXIS_TDATA !== 32'h0) begin fails++; $display("[TB] FAIL reset_tdata: got %h expected 0", M_AXIS_TDATA); end
    RESETN = 1'b1;
    tick(1);
  endtask

  task automatic test_stream();
    int base;
    bit ok;
    applyReset();
    base = capCnt;
    loadFifo(32'h10, 8);
    CFG_PKT_LEN = 9'd4;
    ENABLE      = 1'b1;
    waitBeats(base + 8, 40, ok);
    tests++; if (!ok) begin fails++; $display("[TB] FAIL stream_count: got %0d beats expected 8", capCnt - base); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (capData[base+i] !== 32'h10 + 32'(i)) begin fails++; $display("[TB] FAIL stream_data[%0d]: got %h expected %h", i, capData[base+i], 32'h10 + 32'(i)); end
      tests++; if (capLast[base+i] !== (i % 4 == 3)) begin fails++; $display("[TB] FAIL stream_last[%0d]: got %0b expected %0b", i, capLast[base+i], (i % 4 == 3)); end
    end
    tests++; if (capCyc[base+7] - capCyc[base] !== 7) begin fails++; $display("[TB] FAIL stream_rate: got %0d cycles expected 7", capCyc[base+7] - capCyc[base]); end
    tests++; if (BUSY !== 1'b1) begin fails++; $display("[TB] FAIL stream_busy: got %0b expected 1", BUSY); end
    ENABLE = 1'b0;
    tick(5);
    tests++; if (BUSY !== 1'b0) begin fails++; $display("[TB] FAIL stream_idle: got %0b expected 0", BUSY); end
  endtask

  task automatic test_backpressure();
    int base, v0, s0, o0;
    applyReset();
    base = capCnt; v0 = validErr; s0 = stallErr; o0 = occ2Err;
    loadFifo(32'h10, 8);
    CFG_PKT_LEN = 9'd4;
    ENABLE      = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (capCnt - base >= 8) break;
      M_AXIS_TREADY = ~M_AXIS_TREADY;
      tick(1);
    end
    M_AXIS_TREADY = 1'b1;
    tick(3);
    tests++; if (capCnt - base !== 8) begin fails++; $display("[TB] FAIL bp_count: got %0d beats expected 8", capCnt - base); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (capData[base+i] !== 32'h10 + 32'(i) || capLast[base+i] !== (i % 4 == 3)) begin fails++; $display("[TB] FAIL bp_beat[%0d]: got %h/%0b expected %h/%0b", i, capData[base+i], capLast[base+i], 32'h10 + 32'(i), (i % 4 == 3)); end
    end
    tests++; if (stallErr - s0 !== 0) begin fails++; $display("[TB] FAIL bp_hold: got %0d unstable stalls expected 0", stallErr - s0); end
    tests++; if (occ2Err - o0 !== 0) begin fails++; $display("[TB] FAIL bp_rdcmd_full: got %0d pops at occ=2 expected 0", occ2Err - o0); end
    tests++; if (validErr - v0 !== 0) begin fails++; $display("[TB] FAIL bp_tvalid: got %0d tvalid errors expected 0", validErr - v0); end
    ENABLE = 1'b0;
    tick(5);
  endtask

  task automatic test_enable_drop();
    int base;
    logic [10:0] startPtr;
    applyReset();
    base = capCnt;
    startPtr = rdPtr;
    loadFifo(32'h20, 12);
    CFG_PKT_LEN = 9'd4;
    ENABLE      = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (rdPtr - startPtr >= 11'd2) break;
      tick(1);
    end
    ENABLE = 1'b0;
    tick(15);
    tests++; if (capCnt - base !== 4) begin fails++; $display("[TB] FAIL drop_count: got %0d beats expected 4", capCnt - base); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (capData[base+i] !== 32'h20 + 32'(i) || capLast[base+i] !== (i == 3)) begin fails++; $display("[TB] FAIL drop_beat[%0d]: got %h/%0b expected %h/%0b", i, capData[base+i], capLast[base+i], 32'h20 + 32'(i), (i == 3)); end
    end
    tests++; if (wrPtr - rdPtr !== 11'd8) begin fails++; $display("[TB] FAIL drop_fifo_left: got %0d expected 8", wrPtr - rdPtr); end
    tests++; if (BUSY !== 1'b0) begin fails++; $display("[TB] FAIL drop_busy: got %0b expected 0", BUSY); end
  endtask

  task automatic test_underflow();
    int base;
    bit ok;
    applyReset();
    base = capCnt;
    loadFifo(32'h30, 2);
    CFG_PKT_LEN = 9'd4;
    ENABLE      = 1'b1;
    waitBeats(base + 2, 20, ok);
    tick(5);
    tests++; if (M_AXIS_TVALID !== 1'b0) begin fails++; $display("[TB] FAIL gap_tvalid: got %0b expected 0", M_AXIS_TVALID); end
    tests++; if (capCnt - base !== 2) begin fails++; $display("[TB] FAIL gap_count: got %0d beats expected 2", capCnt - base); end
    tick(5);
    loadFifo(32'h32, 2);
    waitBeats(base + 4, 20, ok);
    tests++; if (!ok) begin fails++; $display("[TB] FAIL gap_resume: got %0d beats expected 4", capCnt - base); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (capData[base+i] !== 32'h30 + 32'(i) || capLast[base+i] !== (i == 3)) begin fails++; $display("[TB] FAIL gap_beat[%0d]: got %h/%0b expected %h/%0b", i, capData[base+i], capLast[base+i], 32'h30 + 32'(i), (i == 3)); end
    end
    ENABLE = 1'b0;
    tick(5);
    tests++; if (BUSY !== 1'b0) begin fails++; $display("[TB] FAIL gap_busy: got %0b expected 0", BUSY); end
  endtask

  task automatic test_max_len();
    int base, lastCnt;
    bit ok;
    applyReset();
    base = capCnt;
    loadFifo(32'h1000, 300);
    CFG_PKT_LEN = 9'd0;
    ENABLE      = 1'b1;
    waitBeats(base + 300, 400, ok);
    tests++; if (!ok) begin fails++; $display("[TB] FAIL max_count: got %0d beats expected 300", capCnt - base); end
    lastCnt = 0;
    for (int i = 0; i < 300; i++) if (capLast[base+i] === 1'b1) lastCnt++;
    tests++; if (capLast[base+255] !== 1'b1) begin fails++; $display("[TB] FAIL max_last256: got %0b expected 1", capLast[base+255]); end
    tests++; if (lastCnt !== 1) begin fails++; $display("[TB] FAIL max_last_count: got %0d expected 1", lastCnt); end
    tests++; if (capData[base+255] !== 32'h10FF) begin fails++; $display("[TB] FAIL max_data256: got %h expected 000010ff", capData[base+255]); end
    tests++; if (capData[base+256] !== 32'h1100) begin fails++; $display("[TB] FAIL max_data257: got %h expected 00001100", capData[base+256]); end
  endtask

  task automatic test_reset_mid();
    int base;
    bit ok;
    logic [10:0] startPtr;
    applyReset();
    startPtr = rdPtr;
    loadFifo(32'h50, 12);
    CFG_PKT_LEN   = 9'd4;
    M_AXIS_TREADY = 1'b0;
    ENABLE        = 1'b1;
    tick(6);
    tests++; if (rdPtr - startPtr !== 11'd2) begin fails++; $display("[TB] FAIL mid_prefill: got %0d pops expected 2", rdPtr - startPtr); end
    tests++; if (M_AXIS_TVALID !== 1'b1) begin fails++; $display("[TB] FAIL mid_tvalid_pre: got %0b expected 1", M_AXIS_TVALID); end
    RESETN = 1'b0;
    #1;
    tests++; if (M_AXIS_TVALID !== 1'b0) begin fails++; $display("[TB] FAIL mid_tvalid: got %0b expected 0", M_AXIS_TVALID); end
    tests++; if (RD_CMD !== 1'b0) begin fails++; $display("[TB] FAIL mid_rdcmd: got %0b expected 0", RD_CMD); end
    tests++; if (BUSY !== 1'b0) begin fails++; $display("[TB] FAIL mid_busy: got %0b expected 0", BUSY); end
    tick(2);
    tests++; if (wrPtr - rdPtr !== 11'd10) begin fails++; $display("[TB] FAIL mid_fifo_kept: got %0d expected 10", wrPtr - rdPtr); end
`ifdef FIFO_AXIS_STATS_EN
    tests++; if (PKT_COUNT !== 32'd0) begin fails++; $display("[TB] FAIL mid_pktcount_reset: got %0d expected 0", PKT_COUNT); end
`endif
    loadFifo(32'h5C, 2);
    base = capCnt;
    M_AXIS_TREADY = 1'b1;
    RESETN        = 1'b1;
    waitBeats(base + 12, 40, ok);
    tick(2);
    tests++; if (!ok) begin fails++; $display("[TB] FAIL mid_resume: got %0d beats expected 12", capCnt - base); end
    tests++; if (capData[base] !== 32'h52) begin fails++; $display("[TB] FAIL mid_first: got %h expected 00000052", capData[base]); end
    tests++; if (capLast[base+3] !== 1'b1 || capLast[base+11] !== 1'b1) begin fails++; $display("[TB] FAIL mid_last: got %0b/%0b expected 1/1", capLast[base+3], capLast[base+11]); end
`ifdef FIFO_AXIS_STATS_EN
    tests++; if (PKT_COUNT !== 32'd3) begin fails++; $display("[TB] FAIL mid_pktcount: got %0d expected 3", PKT_COUNT); end
`endif
    ENABLE = 1'b0;
    tick(5);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_enable_drop();
    test_underflow();
    test_max_len();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
